// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a mandatory turnaround gap between tenures, plus
// a bus watchdog that aborts any access whose responder never returns fc_bus.
module bus_arbiter #(
    parameter int MASTERS = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MASTERS-1:0] bus_req,
    output logic [MASTERS-1:0] bus_grant,
    input  logic               rd_bus,
    input  logic               wr_bus,
    input  logic               fc_bus,
    output logic               watchdog,
    output logic               bus_idle
);

    localparam int PW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PTR_RST  = PW'(MASTERS - 1);
    localparam logic [MASTERS-1:0] ONE = {{(MASTERS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_RELEASE
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [MASTERS-1:0] grant_q, grant_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               armed_q, armed_d;
    logic               wd_q, wd_d;

    logic               pending;
    logic               fire;
    logic               req_any;
    logic [PW-1:0]      pick;

    // First requester strictly after ptr, wrapping; ptr itself is checked last.
    function automatic logic [PW-1:0] next_req(input logic [MASTERS-1:0] req,
                                               input logic [PW-1:0]      ptr);
        logic [PW-1:0] sel;
        logic          found;
        int            idx;
        sel   = ptr;
        found = 1'b0;
        for (int i = 1; i <= MASTERS; i++) begin
            idx = (int'(ptr) + i) % MASTERS;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
        return sel;
    endfunction

    assign req_any = |bus_req;
    assign pick    = next_req(bus_req, ptr_q);

    assign pending = (rd_bus | wr_bus) & ~fc_bus;
    assign fire    = pending & armed_q & (cnt_q == CNT_LAST);

    // Watchdog: one pulse per stall; disarmed until the access completes.
    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        wd_d    = 1'b0;
        if (!pending) begin
            cnt_d   = '0;
            armed_d = 1'b1;
        end else if (armed_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                armed_d = 1'b0;
                wd_d    = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        case (state_q)
            S_IDLE, S_RELEASE: begin
                if (req_any) begin
                    grant_d = ONE << pick;
                    ptr_d   = pick;
                    state_d = S_GRANT;
                end else begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                // ptr holds the current owner; no preemption by other requests.
                if (!bus_req[ptr_q] || fire) begin
                    grant_d = '0;
                    state_d = S_RELEASE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= PTR_RST;
            grant_q <= '0;
            cnt_q   <= '0;
            armed_q <= 1'b1;
            wd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            wd_q    <= wd_d;
        end
    end

    assign bus_grant = grant_q;
    assign watchdog  = wd_q;
    assign bus_idle  = ~|grant_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (MASTERS=4, TIMEOUT=16) with hand-computed
// expected grant/watchdog values checked by immediate assertions.
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] bus_req;
    logic [3:0] bus_grant;
    logic       rd_bus, wr_bus, fc_bus;
    logic       watchdog;
    logic       bus_idle;

    int nvec = 0;
    int nerr = 0;

    bus_arbiter #(.MASTERS(4), .TIMEOUT(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus_req  (bus_req),
        .bus_grant(bus_grant),
        .rd_bus   (rd_bus),
        .wr_bus   (wr_bus),
        .fc_bus   (fc_bus),
        .watchdog (watchdog),
        .bus_idle (bus_idle)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_g(input string tag, input logic [3:0] exp);
        chk({tag, "_grant"}, 32'(bus_grant), 32'(exp));
        chk({tag, "_idle"}, 32'(bus_idle), 32'(exp == 4'b0000));
    endtask

    initial begin
        rst     = 1'b1;
        bus_req = 4'b0000;
        rd_bus  = 1'b0;
        wr_bus  = 1'b0;
        fc_bus  = 1'b0;
        #12;
        chk_g("reset", 4'b0000);
        chk("reset_wd", 32'(watchdog), 32'd0);
        rst = 1'b0;

        // Quiet bus: nothing granted, no watchdog.
        for (int i = 0; i < 10; i++) begin
            step();
            chk_g("quiet", 4'b0000);
            chk("quiet_wd", 32'(watchdog), 32'd0);
        end

        // Two requesters, index 0 wins first; release leaves a one-cycle gap.
        bus_req = 4'b0101;
        step();
        chk_g("first_grant", 4'b0001);
        step();
        chk_g("hold0", 4'b0001);
        bus_req = 4'b0100;
        step();
        chk_g("gap0", 4'b0000);
        step();
        chk_g("grant2", 4'b0100);
        bus_req = 4'b0000;
        step();
        chk_g("rel2", 4'b0000);
        step();
        chk_g("idle2", 4'b0000);

        // Fresh pointer so the rotation starts at master 0.
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Full rotation 0,1,2,3,0 with 3-cycle tenures and a gap between each.
        bus_req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            for (int c = 0; c < 3; c++) begin
                step();
                chk_g("rr_grant", 4'(1 << (n % 4)));
            end
            bus_req[n % 4] = 1'b0;
            step();
            chk_g("rr_gap", 4'b0000);
            bus_req[n % 4] = 1'b1;
        end
        bus_req = 4'b0000;
        step();
        chk_g("rr_end", 4'b0000);

        // ptr=0 now: master 1 is next; stall a read until the watchdog aborts.
        bus_req = 4'b0110;
        step();
        chk_g("wd_m1", 4'b0010);
        rd_bus = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            step();
            chk("wd_wait", 32'(watchdog), 32'd0);
            chk_g("wd_hold", 4'b0010);
        end
        step();
        chk("wd_fire", 32'(watchdog), 32'd1);
        chk_g("wd_abort", 4'b0000);
        step();
        chk("wd_once", 32'(watchdog), 32'd0);
        chk_g("wd_next", 4'b0100);
        for (int e = 0; e < 40; e++) begin
            step();
            chk("wd_disarmed", 32'(watchdog), 32'd0);
        end
        rd_bus = 1'b0;
        step();
        chk("wd_rearm", 32'(watchdog), 32'd0);
        rd_bus = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            step();
            chk("wd2_wait", 32'(watchdog), 32'd0);
        end
        step();
        chk("wd2_fire", 32'(watchdog), 32'd1);
        chk_g("wd2_abort", 4'b0000);
        rd_bus  = 1'b0;
        bus_req = 4'b0000;
        step();
        chk("wd2_once", 32'(watchdog), 32'd0);
        step();

        // fc_bus arriving on the 15th edge clears the count; a full stall then fires.
        wr_bus = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            step();
            chk("fc_wait", 32'(watchdog), 32'd0);
        end
        fc_bus = 1'b1;
        step();
        chk("fc_edge15", 32'(watchdog), 32'd0);
        fc_bus = 1'b0;
        step();
        chk("fc_after", 32'(watchdog), 32'd0);
        for (int e = 2; e <= 15; e++) begin
            step();
            chk("fc2_wait", 32'(watchdog), 32'd0);
        end
        step();
        chk("fc2_fire", 32'(watchdog), 32'd1);
        wr_bus = 1'b0;
        step();
        chk("fc2_once", 32'(watchdog), 32'd0);

        // ptr=2: master 1 granted, then async reset mid-cycle drops it at once.
        bus_req = 4'b0010;
        step();
        chk_g("pre_rst", 4'b0010);
        #3;
        rst = 1'b1;
        #1;
        chk_g("async_rst", 4'b0000);
        bus_req = 4'b0011;
        step();
        chk_g("in_rst", 4'b0000);
        rst = 1'b0;
        step();
        chk_g("post_rst", 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Central arbiter and bus monitor for the shared system bus. It receives `bus_req` from every bus master (DMA channels and other initiators) and returns a one-hot registered `bus_grant`. It also runs the bus watchdog that aborts any transfer whose responder never asserts `fc_bus`. When no master is granted, the CPU is the implicit default owner of the bus.

## Interface
- MASTERS, 4, number of requesting masters (2..8); index 0 is searched first after reset
- TIMEOUT, 16, consecutive unacknowledged access cycles before the watchdog fires (2..1024)
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- bus_req  input  MASTERS  per-master request, level, held for the whole tenure
- bus_grant  output  MASTERS  one-hot grant, registered
- rd_bus  input  1  bus read strobe (monitored only)
- wr_bus  input  1  bus write strobe (monitored only)
- fc_bus  input  1  function-complete from the responder (monitored only)
- watchdog  output  1  one-cycle abort pulse, broadcast to all masters
- bus_idle  output  1  high when no master is granted (the CPU owns the bus)

## Operation
- The top level provides pull-downs on rd_bus, wr_bus and fc_bus. The block treats these three inputs as plain logic.
- State machine:
  - IDLE: no grant. If any bus_req is high, choose k, the first requester cyclically after ptr. Set bus_grant[k]=1, ptr<=k, go to GRANT.
  - GRANT: bus_grant[k] stays high.
    - If bus_req[k]=0 or the watchdog fires, clear all grants and go to RELEASE.
    - Requests from other masters are ignored; there is no preemption.
  - RELEASE: all grants low for exactly this cycle. On the next edge, arbitrate exactly as in IDLE; if no request is pending, go to IDLE.
- Round-robin pointer ptr:
  - Reset value is MASTERS-1.
  - The master that just released or was aborted has the lowest priority in the next arbitration.
- Watchdog, active in every state:
  - pending = (rd_bus | wr_bus) & ~fc_bus.
  - The counter increments on each edge where pending=1 and armed=1.
  - The counter clears to 0 on any edge where pending=0; the same edge sets armed=1.
  - When pending=1, armed=1 and cnt=TIMEOUT-1: watchdog<=1 for one cycle, cnt<=0, armed<=0.
  - While armed=0, the counter holds at 0. No further pulse is possible until pending drops.
  - Counter width is clog2(TIMEOUT)+1; it never wraps.
- Watchdog firing in IDLE or RELEASE produces the pulse only; there is no grant to revoke.
- bus_idle = (bus_grant == 0). It is derived from registered state, so it is glitch-free.

## Timing
- Reset values:
  - bus_grant=0, watchdog=0, bus_idle=1.
  - State IDLE, cnt=0, armed=1, ptr=MASTERS-1.
- Asserting rst clears bus_grant immediately, without waiting for a clock edge. This applies mid-tenure as well.
- Grant latency:
  - bus_req is sampled high at edge n; bus_grant is high from edge n onward, visible to the master in cycle n+1.
  - Minimum is one cycle; there is no combinational path from request to grant.
- Release:
  - bus_req[k] is sampled low at edge n; bus_grant[k] falls at edge n.
  - The next grant rises at edge n+1 at the earliest.
  - This one-cycle gap with all grants low is mandatory; it provides tri-state turnaround.
- Watchdog timing: pending is sampled high on TIMEOUT consecutive edges. watchdog is high in the cycle following the last of those edges.
- Simultaneous events:
  - Watchdog fire and release of bus_req[k] on the same edge: grant falls once, watchdog pulses once, state goes to RELEASE.
  - fc_bus high on the same edge that cnt would reach TIMEOUT-1: pending=0, so there is no pulse and cnt clears.
  - A new request arriving during RELEASE is considered at the RELEASE edge.
- A master whose bus_req stays high after a watchdog abort is re-granted only after every other current requester has been served.

## Test plan
All scenarios use MASTERS=4, TIMEOUT=16.
- Reset, then bus_req=4'b0000 for 10 cycles -> bus_grant=0, bus_idle=1, watchdog=0 throughout.
- bus_req=4'b0101 from reset -> bus_grant=0001 one cycle later. Drop req[0] -> exactly one cycle of bus_grant=0, then bus_grant=0100.
- bus_req=4'b1111. Each master drops its request after 3 granted cycles and re-raises it the following cycle -> grant order 0,1,2,3,0, with a one-cycle gap between each.
- Master 1 granted, rd_bus=1 and fc_bus=0 for 16 edges -> watchdog high for exactly one cycle and bus_grant falls at the same edge. With req[2] high, bus_grant=0100 after the gap. rd_bus held high a further 40 cycles -> no second pulse. rd_bus low then high again -> counting restarts.
- wr_bus=1 with fc_bus asserted on the 15th edge -> no watchdog pulse and the counter clears. A second 16-cycle stall -> a pulse occurs.
- rst asserted mid-cycle while bus_grant=0010 -> bus_grant=0 before the next clk edge. After release with bus_req=4'b0011 -> master 0 is granted first.
